// File: rtl/latency_pkg.sv
// Shared types and helpers for the latency reconfiguration arbiter.
package latency_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int LAT_MIN = 1;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/latency_quiet_mon.sv
// Watches the delay-line input and reports when no edge can still be in flight.
module latency_quiet_mon #(
    parameter int LSIZE = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic [LSIZE-1:0] lat,
    output logic             quiet
);

    logic             d_q;
    logic             d_edge;
    logic [LSIZE-1:0] qcnt;

    assign d_edge = (d != d_q);

    // d_q reloads from d on reset so a static high level is not seen as an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q  <= d;
            qcnt <= '1;
        end else begin
            d_q <= d;
            if (d_edge)
                qcnt <= '0;
            else if (qcnt != '1)
                qcnt <= qcnt + LSIZE'(1);
        end
    end

    assign quiet = (qcnt >= lat) && !d_edge;

endmodule

// File: rtl/latency_cfg_arbiter.sv
// Round-robin latency reconfiguration arbiter for a programmable delay line.
// Optional drain timeout: define LATENCY_DRAIN_TIMEOUT_EN.
module latency_cfg_arbiter
    import latency_pkg::*;
#(
    parameter int LSIZE    = 10,
    parameter int NREQ     = 2,
    parameter int LAT_INIT = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LSIZE-1:0] req_lat,
    output logic [NREQ-1:0]       ack,
    output logic                  ack_err,
    output logic [LSIZE-1:0]      lat,
    output logic                  busy,
    output logic                  drain_to
);

    localparam int IW = idx_width(NREQ);

    state_t           state, state_nx;
    logic [IW-1:0]    rr_ptr, rr_nx;
    logic [IW-1:0]    gnt_idx, gidx_nx;
    logic [LSIZE-1:0] gnt_lat, glat_nx;
    logic [LSIZE-1:0] lat_nx;
    logic [NREQ-1:0]  ack_nx;
    logic             err_nx;
    logic             quiet;
    logic [IW:0]      pick;
    logic [IW-1:0]    pick_idx;

    latency_quiet_mon #(.LSIZE(LSIZE)) u_mon (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .lat   (lat),
        .quiet (quiet)
    );

    // Lowest requester at or above p, wrapping modulo NREQ.
    function automatic logic [IW:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IW-1:0]   p
    );
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= NREQ)
                j = j - NREQ;
            if (r[j])
                res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    assign pick     = rr_pick(req, rr_ptr);
    assign pick_idx = pick[IW-1:0];
    assign busy     = (state != IDLE);

`ifdef LATENCY_DRAIN_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tcnt, tcnt_nx;
    logic          to_nx;
    logic          to_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt <= '0;
            to_r <= 1'b0;
        end else begin
            tcnt <= tcnt_nx;
            to_r <= to_nx;
        end
    end

    assign drain_to = to_r;
`else
    assign drain_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            gnt_lat <= '0;
            lat     <= LSIZE'(LAT_INIT);
            ack     <= '0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_nx;
            gnt_idx <= gidx_nx;
            gnt_lat <= glat_nx;
            lat     <= lat_nx;
            ack     <= ack_nx;
            ack_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        gidx_nx  = gnt_idx;
        glat_nx  = gnt_lat;
        lat_nx   = lat;
        ack_nx   = '0;
        err_nx   = 1'b0;
`ifdef LATENCY_DRAIN_TIMEOUT_EN
        tcnt_nx  = tcnt;
        to_nx    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (pick[IW]) begin
                    gidx_nx  = pick_idx;
                    glat_nx  = req_lat[int'(pick_idx)*LSIZE +: LSIZE];
                    rr_nx    = (int'(pick_idx) == NREQ - 1) ?
                               '0 : pick_idx + IW'(1);
                    state_nx = DRAIN;
`ifdef LATENCY_DRAIN_TIMEOUT_EN
                    tcnt_nx  = '0;
`endif
                end
            end
            DRAIN: begin
                if (gnt_lat == '0) begin
                    ack_nx[gnt_idx] = 1'b1;
                    err_nx          = 1'b1;
                    state_nx        = HOLD;
                end else if (gnt_lat == lat) begin
                    ack_nx[gnt_idx] = 1'b1;
                    state_nx        = HOLD;
                end else if (quiet) begin
                    lat_nx          = gnt_lat;
                    ack_nx[gnt_idx] = 1'b1;
                    state_nx        = HOLD;
`ifdef LATENCY_DRAIN_TIMEOUT_EN
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    lat_nx          = gnt_lat;
                    ack_nx[gnt_idx] = 1'b1;
                    to_nx           = 1'b1;
                    state_nx        = HOLD;
                end else begin
                    tcnt_nx = tcnt + TW'(1);
`endif
                end
            end
            HOLD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_latency_cfg_arbiter.sv
// Directed plus randomized checks of latency_cfg_arbiter against a reference model.
module tb_latency_cfg_arbiter;

    localparam int LSIZE    = 10;
    localparam int NREQ     = 2;
    localparam int LAT_INIT = 1;
    localparam int TIMEOUT  = 16;
    localparam int MAXQ     = (1 << LSIZE) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  d;
    logic [NREQ-1:0]       req;
    logic [NREQ*LSIZE-1:0] req_lat;
    logic [NREQ-1:0]       ack;
    logic                  ack_err;
    logic [LSIZE-1:0]      lat;
    logic                  busy;
    logic                  drain_to;

    latency_cfg_arbiter #(
        .LSIZE(LSIZE), .NREQ(NREQ), .LAT_INIT(LAT_INIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .req(req), .req_lat(req_lat),
        .ack(ack), .ack_err(ack_err), .lat(lat), .busy(busy), .drain_to(drain_to)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int tog_per = 0;

    // Reference model: one pending request at a time, tracked by phase.
    int m_phase;          // 0 free, 1 waiting for a safe apply, 2 ack visible
    int m_rr, m_g, m_gl, m_lat, m_stable, m_wait;
    int m_ack, m_err, m_to;
    logic m_dprev;

    logic                  p_rst, p_d;
    logic [NREQ-1:0]       p_req;
    logic [NREQ*LSIZE-1:0] p_rlat;

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit safe, moved;
        int j;
        if (!p_rst) begin
            m_phase = 0; m_rr = 0; m_lat = LAT_INIT;
            m_ack = 0; m_err = 0; m_to = 0;
            m_stable = MAXQ; m_dprev = p_d;
            return;
        end
        moved = (p_d != m_dprev);
        safe  = !moved && (m_stable >= m_lat);
        m_stable = moved ? 0 : ((m_stable < MAXQ) ? m_stable + 1 : MAXQ);
        m_dprev = p_d;
        m_ack = 0; m_err = 0; m_to = 0;
        if (m_phase == 0) begin
            if (p_req != 0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    j = (m_rr + k) % NREQ;
                    if (p_req[j]) m_g = j;
                end
                m_gl = int'(p_rlat[m_g*LSIZE +: LSIZE]);
                m_rr = (m_g + 1) % NREQ;
                m_wait = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_gl == 0) begin
                m_ack = 1 << m_g; m_err = 1; m_phase = 2;
            end else if (m_gl == m_lat) begin
                m_ack = 1 << m_g; m_phase = 2;
            end else if (safe) begin
                m_lat = m_gl; m_ack = 1 << m_g; m_phase = 2;
`ifdef LATENCY_DRAIN_TIMEOUT_EN
            end else if (m_wait == TIMEOUT - 1) begin
                m_lat = m_gl; m_ack = 1 << m_g; m_to = 1; m_phase = 2;
            end else begin
                m_wait++;
`endif
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic tick();
        if (tog_per != 0 && (cyc % tog_per) == 0) d = ~d;
        p_rst = rst_n; p_d = d; p_req = req; p_rlat = req_lat;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk("lat", int'(lat), m_lat);
        chk("ack", int'(ack), m_ack);
        chk("ack_err", int'(ack_err), m_err);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("drain_to", int'(drain_to), m_to);
        for (int i = 0; i < NREQ; i++)
            if (ack[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int i, input int v);
        req_lat[i*LSIZE +: LSIZE] = LSIZE'(v);
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int lim, output int n,
                            output logic [NREQ-1:0] a);
        n = 0; a = '0;
        while (a == '0 && n < lim) begin
            tick();
            n++;
            a = ack;
        end
        if (a == '0) begin
            ntests++; nfail++;
            $error("FAIL ack_timeout: observed no ack expected ack within %0d", lim);
        end
    endtask

    int n;
    logic [NREQ-1:0] a;
    int order[4];

    initial begin
        rst_n = 1'b0; d = 1'b0; req = '0; req_lat = '0;
        tick(); tick();
        chk("rst_lat", int'(lat), LAT_INIT);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // quiet line: request 5 -> applied two edges later
        raise(0, 5);
        tick();
        chk("t1_busy_e1", int'(busy), 1);
        chk("t1_lat_e1", int'(lat), LAT_INIT);
        tick();
        chk("t1_lat_e2", int'(lat), 5);
        chk("t1_ack_e2", int'(ack), 1);
        chk("t1_err_e2", int'(ack_err), 0);
        tick();
        chk("t1_ack_clr", int'(ack), 0);

        // set lat 8, then an edge on d delays the apply of 3
        raise(1, 8);
        wait_ack(20, n, a);
        tick(); tick(); tick();
        d = ~d;
        tick();
        raise(1, 3);
        wait_ack(30, n, a);
        chk("t2_edges", n, 9);
        chk("t2_lat", int'(lat), 3);
        tick();

        // both requesting continuously: strict alternation
        raise(0, 6); raise(1, 2);
        for (int k = 0; k < 4; k++) begin
            wait_ack(30, n, a);
            order[k] = a[1] ? 1 : 0;
            tick();
            if (order[k] == 0) raise(0, 6); else raise(1, 2);
        end
        chk("t3_o0", order[0], 0);
        chk("t3_o1", order[1], 1);
        chk("t3_o2", order[2], 0);
        chk("t3_o3", order[3], 1);
        req = '0;
        tick(); tick(); tick();

        // zero latency is rejected
        raise(0, 0);
        wait_ack(10, n, a);
        chk("t4_n", n, 2);
        chk("t4_err", int'(ack_err), 1);
        chk("t4_lat", int'(lat), 2);
        tick();

        // periodic activity on d blocks the apply
        raise(0, 10);
        wait_ack(30, n, a);
        tick();
        tog_per = 4;
        repeat (6) tick();
        raise(1, 7);
`ifdef LATENCY_DRAIN_TIMEOUT_EN
        wait_ack(40, n, a);
        chk("t5_to_n", n, 17);
        chk("t5_to_flag", int'(drain_to), 1);
        chk("t5_to_lat", int'(lat), 7);
        tog_per = 0;
`else
        repeat (40) tick();
        chk("t5_hold_lat", int'(lat), 10);
        chk("t5_hold_busy", int'(busy), 1);
        tog_per = 0;
        wait_ack(40, n, a);
        chk("t5_late_lat", int'(lat), 7);
`endif
        tick(); tick();

        // reset during the drain abandons the grant; req is served again
        tog_per = 3;
        raise(1, 9);
        repeat (5) tick();
        chk("t6_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_lat", int'(lat), LAT_INIT);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_ack", int'(ack), 0);
        rst_n = 1'b1;
        tog_per = 0;
        wait_ack(30, n, a);
        chk("t6_regrant", int'(a), 2);
        chk("t6_lat", int'(lat), 9);
        tick();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) d = ~d;
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && !ack[i] && $urandom_range(0, 2) == 0)
                    raise(i, int'($urandom_range(0, 12)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
